// File: rtl/count_seq_ctrl.sv
// Prescaled step counter: IDLE/RUN/PAUSE sequencer driven by START/STOP/PAUSE.
// Ports: clk, rst, cmd_* handshake and config in; count, busy, paused, tick, done, err out.
module count_seq_ctrl #(
  parameter int PRESC_W = 4,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [CNT_W-1:0]   cmd_limit,
  input  logic [PRESC_W-1:0] cmd_presc,
  input  logic               cmd_periodic,
  output logic [CNT_W-1:0]   count,
  output logic               busy,
  output logic               paused,
  output logic               tick,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
  } state_t;

  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_PAUSE = 2'b11;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   lim_q, lim_d;
  logic [PRESC_W-1:0] pv_q, pv_d;
  logic               per_q, per_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic is_start, is_stop, is_pause;

  assign is_start = cmd_valid && (cmd_op == OP_START);
  assign is_stop  = cmd_valid && (cmd_op == OP_STOP);
  assign is_pause = cmd_valid && (cmd_op == OP_PAUSE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    lim_d   = lim_q;
    pv_d    = pv_q;
    per_d   = per_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    // Any non-NOP command wins over a coincident step.
    unique case (1'b1)
      is_start: begin
        if (cmd_limit == '0) begin
          err_d = 1'b1;
        end else begin
          lim_d   = cmd_limit;
          pv_d    = cmd_presc;
          per_d   = cmd_periodic;
          cnt_d   = '0;
          pcnt_d  = '0;
          state_d = S_RUN;
        end
      end
      is_stop: begin
        cnt_d   = '0;
        pcnt_d  = '0;
        state_d = S_IDLE;
      end
      is_pause: begin
        if (state_q == S_RUN) begin
          state_d = S_PAUSE;
        end else if (state_q == S_PAUSE) begin
          state_d = S_RUN;
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        if (state_q == S_RUN) begin
          if (pcnt_q == pv_q) begin
            pcnt_d = '0;
            if (cnt_q < lim_q) begin
              cnt_d = cnt_q + 1'b1;
            end else begin
              tick_d = 1'b1;
              if (per_q) begin
                cnt_d = '0;
              end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      lim_q   <= '0;
      pv_q    <= '0;
      per_q   <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      lim_q   <= lim_d;
      pv_q    <= pv_d;
      per_q   <= per_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = ~rst;
  assign count     = cnt_q;
  assign busy      = (state_q != S_IDLE);
  assign paused    = (state_q == S_PAUSE);
  assign tick      = tick_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Scoreboard bench for count_seq_ctrl: elapsed-time reference model,
// directed scenarios followed by random command traffic.
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_limit;
  logic [3:0] cmd_presc;
  logic       cmd_periodic;
  logic [3:0] count;
  logic       busy, paused, tick, done, err;

  always #5 clk = ~clk;

  count_seq_ctrl #(.PRESC_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_limit(cmd_limit),
    .cmd_presc(cmd_presc), .cmd_periodic(cmd_periodic),
    .count(count), .busy(busy), .paused(paused),
    .tick(tick), .done(done), .err(err)
  );

  typedef struct {
    int cnt;
    bit busy;
    bit paused;
    bit tick;
    bit done;
    bit err;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // Model: 0 idle, 1 run, 2 pause; m_t = cycles elapsed in current period.
  int m_st, m_lim, m_p, m_t, m_idle_cnt;
  bit m_per;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_lim = 0; m_p = 0; m_per = 0;
    m_t = 0; m_idle_cnt = 0;
    sb.delete();
  endtask

  task automatic model_edge();
    exp_t e;
    e.tick = 0; e.done = 0; e.err = 0;
    if (cmd_valid && cmd_op == 2'd1) begin
      if (cmd_limit == 0) e.err = 1;
      else begin
        m_lim = cmd_limit; m_p = cmd_presc;
        m_per = cmd_periodic; m_t = 0; m_st = 1;
      end
    end else if (cmd_valid && cmd_op == 2'd2) begin
      m_st = 0; m_t = 0; m_idle_cnt = 0;
    end else if (cmd_valid && cmd_op == 2'd3) begin
      if (m_st == 1) m_st = 2;
      else if (m_st == 2) m_st = 1;
      else e.err = 1;
    end else if (m_st == 1) begin
      m_t++;
      if (m_t == (m_lim + 1) * (m_p + 1)) begin
        e.tick = 1;
        if (m_per) m_t = 0;
        else begin
          m_st = 0; m_idle_cnt = m_lim; e.done = 1;
        end
      end
    end
    e.cnt = (m_st == 0) ? m_idle_cnt : m_t / (m_p + 1);
    e.busy = (m_st != 0);
    e.paused = (m_st == 2);
    sb.push_back(e);
  endtask

  task automatic cyc(bit v, logic [1:0] op, logic [3:0] l,
                     logic [3:0] p, bit per);
    cmd_valid = v; cmd_op = op; cmd_limit = l;
    cmd_presc = p; cmd_periodic = per;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic nops(int n);
    for (int i = 0; i < n; i++) cyc(1, 2'd0, 4'd0, 4'd0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && sb.size() > 0) begin
      e = sb.pop_front();
      chk("count", count, e.cnt);
      chk("busy", busy, e.busy);
      chk("paused", paused, e.paused);
      chk("tick", tick, e.tick);
      chk("done", done, e.done);
      chk("err", err, e.err);
    end
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 0; cmd_op = 0; cmd_limit = 0;
    cmd_presc = 0; cmd_periodic = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_paused", paused, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_pulses", {tick, done, err}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready", cmd_ready, 1);

    // one-shot limit 3, P 0
    cyc(1, 2'd1, 4'd3, 4'd0, 0);
    nops(6);
    // illegal START and PAUSE in idle
    cyc(1, 2'd1, 4'd0, 4'd2, 1);
    nops(2);
    cyc(1, 2'd3, 4'd0, 4'd0, 0);
    nops(2);
    // periodic limit 2, P 1
    cyc(1, 2'd1, 4'd2, 4'd1, 1);
    nops(14);
    cyc(1, 2'd2, 4'd0, 4'd0, 0);
    nops(2);
    // pause at count 2 for 5 cycles
    cyc(1, 2'd1, 4'd7, 4'd0, 0);
    nops(2);
    cyc(1, 2'd3, 4'd0, 4'd0, 0);
    nops(5);
    cyc(1, 2'd3, 4'd0, 4'd0, 0);
    nops(8);
    // STOP on the terminal-step edge
    cyc(1, 2'd1, 4'd1, 4'd0, 1);
    nops(1);
    cyc(1, 2'd2, 4'd0, 4'd0, 0);
    nops(3);
    // async reset mid-run at count 2
    cyc(1, 2'd1, 4'd7, 4'd0, 0);
    nops(2);
    @(negedge clk);
    #1;
    chk("pre_rst_count", count, 2);
    rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pulses", {tick, done, err}, 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("arst_hold", {count, busy, tick, done, err}, 0);
    @(negedge clk);
    rst = 1'b0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit v;
      logic [1:0] op;
      r = $urandom_range(0, 99);
      v = ($urandom_range(0, 9) != 0);
      if (r < 3) op = 2'd1;
      else if (r < 5) op = 2'd2;
      else if (r < 9) op = 2'd3;
      else op = 2'd0;
      cyc(v, op, 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end
    nops(1);
    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 Parameter PRESC_W, default 4: width of the prescaler divide value.
REQ-002 Parameter CNT_W, default 4: width of the sequenced counter and its limit.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both 1 at a rising edge.
REQ-007 cmd_op  input  2  00 NOP, 01 START, 10 STOP, 11 PAUSE (pause/resume toggle).
REQ-008 cmd_limit  input  CNT_W  terminal count value, sampled only on an accepted START.
REQ-009 cmd_presc  input  PRESC_W  prescale value P, sampled on START; the counter steps every P+1 cycles.
REQ-010 cmd_periodic  input  1  1 = auto-reload, 0 = one-shot, sampled on START.
REQ-011 count  output  CNT_W  current counter value.
REQ-012 busy  output  1  1 in RUN or PAUSE.
REQ-013 paused  output  1  1 in PAUSE.
REQ-014 tick  output  1  registered one-cycle pulse per terminal step.
REQ-015 done  output  1  registered one-cycle pulse on one-shot completion.
REQ-016 err  output  1  registered one-cycle pulse on an illegal command.

Function
REQ-017 The block SHALL implement three states: IDLE, RUN and PAUSE.
REQ-018 cmd_ready SHALL be 1 whenever rst is 0; NOP SHALL be accepted with no effect.
REQ-019 An accepted START with cmd_limit=0 SHALL be illegal: err pulses, and state, count and the latched config are unchanged.
REQ-020 An accepted legal START in any state SHALL:
- latch limit, presc and periodic;
- clear count and the prescaler;
- enter RUN on the same edge.
REQ-021 In RUN the prescaler SHALL increment every cycle; when it equals the latched P, it returns to 0 and a step occurs.
REQ-022 On a step with count < limit, count SHALL increment by 1 with no wrap beyond limit.
REQ-023 On a step with count == limit (terminal step), tick SHALL be high in the following cycle.
- Periodic: count returns to 0 and the block stays in RUN.
- One-shot: count holds limit, state goes to IDLE, and done is high together with tick.
REQ-024 The period SHALL be (limit+1)*(P+1) cycles; the one-shot terminal step SHALL occur exactly (limit+1)*(P+1) edges after the START accept edge.
REQ-025 An accepted STOP in any state SHALL clear count and the prescaler, enter IDLE, and pulse nothing.
REQ-026 An accepted PAUSE SHALL behave as follows:
- in RUN: enter PAUSE with count and prescaler frozen;
- in PAUSE: return to RUN and continue from the frozen values;
- in IDLE: illegal, err pulses, no state change.
REQ-027 An accepted command SHALL take priority over a coincident step: the step is suppressed and no tick or done is generated that cycle.
REQ-028 tick, done and err SHALL each be high for exactly one cycle per event, never for two consecutive cycles from a single event.
REQ-029 In IDLE after one-shot completion, count SHALL hold limit until the next START or STOP.

Reset
REQ-030 While rst=1, the block SHALL hold:
- state IDLE;
- count=0 and prescaler=0;
- latched config: limit 0, presc 0, periodic 0;
- busy, paused, tick, done, err and cmd_ready all 0.
REQ-031 rst assertion mid-RUN or mid-PAUSE SHALL take effect immediately without a clock, and any pending pulse SHALL be dropped.

Verification
REQ-032 Reset: assert rst asynchronously mid-RUN at count=2 -> count=0 and busy=0 before the next clk edge; all pulses stay 0.
REQ-033 One-shot: START limit=3, P=0, periodic=0 -> count 0,1,2,3 on successive cycles; tick=done=1 for one cycle after the 4th post-accept edge; then busy=0 and count stays 3.
REQ-034 Periodic: START limit=2, P=1, periodic=1 -> count 0,0,1,1,2,2,0,...; tick every 6 cycles; done never asserted; busy stays 1.
REQ-035 Pause: START limit=7, P=0; PAUSE at count=2 held 5 cycles, then PAUSE -> count stays 2 and paused=1 while held, then resumes 3,4,...; the terminal tick is delayed by exactly the pause length.
REQ-036 Collision: STOP accepted on the terminal-step edge (limit=1, P=0, periodic) -> no tick, count=0, IDLE.
REQ-037 Illegal: START limit=0 in IDLE -> err pulses once and busy stays 0; PAUSE in IDLE -> err pulses once; NOP in RUN -> no change.
